// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side pointer/status controller for the async FIFO, read clock domain only.
// Latency: accepted read updates pointer/status at the same edge; write visibility SYNC_STAGES+1 edges.
// Backpressure: reads are accepted only while empty=0; a read while empty is dropped and flagged.
//
// Ports:
//   rclk, r_rst       read clock, asynchronous active-high reset
//   r_en              read request from the consumer
//   wptr_gray         Gray write pointer straight from the write domain (unsynchronised)
//   rptr_gray         registered Gray read pointer, sent to the write domain
//   raddr             RAM read address (head entry)
//   empty             registered, no readable entry
//   almost_empty      registered, occupancy <= AE_LEVEL
//   rd_level          registered occupancy, 0..2^ADDR_W
//   underflow         one-cycle pulse, read requested while empty
module rd_ptr_empty_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              rclk,
  input  logic              r_rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] raddr,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AE_THR = PW'(AE_LEVEL);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Write pointer synchroniser
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] wsync_gray;
  logic [ADDR_W:0] wsync_bin;

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wsync_gray = sync_q[SYNC_STAGES-1];
  assign wsync_bin  = gray2bin(wsync_gray);

  // Read pointer and status state
  logic [ADDR_W:0] rbin_q,  rbin_d;
  logic [ADDR_W:0] rgray_q, rgray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            empty_q, empty_d;
  logic            ae_q,    ae_d;
  logic            underflow_q, underflow_d;
  logic            accept;

  always_comb begin
    accept      = r_en & ~empty_q;
    rbin_d      = rbin_q + PW'(accept);
    rgray_d     = rbin_d ^ (rbin_d >> 1);
    // Occupancy is computed against the post-read pointer so a read and a newly
    // arrived write pointer in the same cycle are both reflected in one update.
    level_d     = wsync_bin - rbin_d;
    // Full-width Gray compare: the wrap bit keeps "full" from aliasing to "empty".
    empty_d     = (rgray_d == wsync_gray);
    ae_d        = (level_d <= AE_THR);
    underflow_d = r_en & empty_q;
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      underflow_q <= underflow_d;
    end
  end

  assign rptr_gray    = rgray_q;
  assign raddr        = rbin_q[ADDR_W-1:0];
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
module tb_rd_ptr_empty_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;

  logic          rclk = 1'b0;
  logic          r_rst;
  logic          r_en;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded counts of writes issued and reads accepted,
  // plus a delay line giving the write count the read side can see.
  int rd_cnt;
  int w_cnt;
  int lvl_m;
  bit emp_m;
  int hist[$];

  rd_ptr_empty_ctrl #(
    .ADDR_W      (AW),
    .SYNC_STAGES (SS),
    .AE_LEVEL    (AE)
  ) dut (
    .rclk         (rclk),
    .r_rst        (r_rst),
    .r_en         (r_en),
    .wptr_gray    (wptr_gray),
    .rptr_gray    (rptr_gray),
    .raddr        (raddr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    rd_cnt = 0;
    w_cnt  = 0;
    lvl_m  = 0;
    emp_m  = 1'b1;
    hist.delete();
    repeat (SS) hist.push_back(0);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_rptr_gray"}, rptr_gray, 0);
    chk({p, "_raddr"}, raddr, 0);
    chk({p, "_empty"}, empty, 1);
    chk({p, "_almost_empty"}, almost_empty, 1);
    chk({p, "_rd_level"}, rd_level, 0);
    chk({p, "_underflow"}, underflow, 0);
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic step(input bit ren);
    logic [AW:0] prev;
    bit          und_m;
    int          w_vis;
    r_en      = ren;
    wptr_gray = to_gray(w_cnt);
    prev      = rptr_gray;
    @(posedge rclk);
    und_m = ren && emp_m;
    if (ren && !emp_m) rd_cnt++;
    hist.push_back(w_cnt);
    w_vis = hist.pop_front();
    lvl_m = w_vis - rd_cnt;
    emp_m = (lvl_m == 0);
    #1;
    chk("rd_level", rd_level, lvl_m);
    chk("empty", empty, emp_m);
    chk("almost_empty", almost_empty, lvl_m <= AE);
    chk("underflow", underflow, und_m);
    chk("raddr", raddr, rd_cnt % DEPTH);
    chk("rptr_gray", rptr_gray, to_gray(rd_cnt));
    chk("gray_step", $countones(prev ^ rptr_gray) <= 1, 1);
  endtask

  initial begin
    r_rst     = 1'b1;
    r_en      = 1'b0;
    wptr_gray = '0;
    model_reset();
    #2;
    check_reset_vals("por");
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    r_rst = 1'b0;

    // Fill to 3 entries, visible after 3 edges
    w_cnt = 3;
    step(0);
    step(0);
    chk("fill_empty_edge2", empty, 1);
    step(0);
    chk("fill_level", rd_level, 3);
    chk("fill_empty", empty, 0);
    chk("fill_ae", almost_empty, 0);
    chk("head_raddr", raddr, 0);

    // Drain back-to-back
    step(1);
    chk("rd1_raddr", raddr, 1);
    chk("rd1_level", rd_level, 2);
    chk("rd1_ae", almost_empty, 1);
    step(1);
    chk("rd2_raddr", raddr, 2);
    chk("rd2_level", rd_level, 1);
    step(1);
    chk("rd3_level", rd_level, 0);
    chk("rd3_empty", empty, 1);

    // Underflow on two consecutive reads while empty
    step(1);
    chk("uf1", underflow, 1);
    step(1);
    chk("uf2", underflow, 1);
    chk("uf_raddr", raddr, 3);
    chk("uf_rptr_gray", rptr_gray, 5'b00010);
    step(0);
    chk("uf_clear", underflow, 0);

    // Move read pointer to 5, then reset asynchronously mid-cycle
    w_cnt = 5;
    repeat (3) step(0);
    step(1);
    step(1);
    chk("pre_rst_raddr", raddr, 5);
    #3;
    r_rst     = 1'b1;
    r_en      = 1'b1;
    wptr_gray = to_gray(9);
    #1;
    check_reset_vals("arst");
    repeat (2) @(posedge rclk);
    #1;
    check_reset_vals("arst_hold");
    r_en      = 1'b0;
    wptr_gray = '0;
    @(negedge rclk);
    r_rst = 1'b0;
    model_reset();

    // Full: write pointer one lap ahead
    w_cnt = DEPTH;
    repeat (3) step(0);
    chk("full_level", rd_level, DEPTH);
    chk("full_empty", empty, 0);
    chk("full_ae", almost_empty, 0);

    // Read down to one entry, then read as the next write arrives
    repeat (DEPTH - 1) step(1);
    chk("one_left_level", rd_level, 1);
    w_cnt = DEPTH + 1;
    step(0);
    step(0);
    step(1);
    chk("simul_level", rd_level, 1);
    chk("simul_empty", empty, 0);

    // Alternating writes and reads across the pointer wrap
    repeat (40) begin
      w_cnt++;
      step(0);
      step(1);
    end

    // Random traffic, writer never more than DEPTH ahead
    repeat (800) begin
      if ($urandom_range(0, 1) == 1 && (w_cnt - rd_cnt) < DEPTH) w_cnt++;
      step($urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
